// File: rtl/prbs4_checker_if.sv
// Bundle between a serial PRBS-4 source and the checker.
// The producer drives in_valid/din/clr. There is no ready: every cycle with in_valid=1 delivers one bit.
interface prbs4_checker_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             din;
   logic             clr;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_count;
   logic             state_dbg;

   modport master (
      output in_valid, din, clr,
      input  locked, err, err_count, state_dbg
   );

   modport slave (
      input  in_valid, din, clr,
      output locked, err, err_count, state_dbg
   );
endinterface

// File: rtl/prbs4_checker.sv
// PRBS-4 (x^4+x^3+1) serial checker with HUNT/LOCK synchronisation and a saturating error count.
module prbs4_checker #(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 8
) (
   input logic            clk,
   input logic            rst,
   prbs4_checker_if.slave bus
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int SW = $clog2(LOSS_CNT + 1);

   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [3:0]       s_q, s_d;
   logic [2:0]       fill_q, fill_d;
   logic [MW-1:0]    match_q, match_d;
   logic [SW-1:0]    miss_q, miss_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             p;

   assign p = s_q[3] ^ s_q[2];

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      fill_d  = fill_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      if (bus.in_valid) begin
         case (state_q)
            HUNT: begin
               s_d = {s_q[2:0], bus.din};
               if (fill_q != 3'd4) begin
                  fill_d = fill_q + 3'd1;
               end else if ((bus.din == p) && (s_q != 4'b0000)) begin
                  if (match_q == MW'(LOCK_CNT - 1)) begin
                     state_d = LOCK;
                     match_d = '0;
                  end else begin
                     match_d = match_q + MW'(1);
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCK: begin
               // Free-run on the prediction so one flipped bit yields exactly one err.
               s_d = {s_q[2:0], p};
               if (bus.din != p) begin
                  err_d = 1'b1;
                  if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                  if (miss_q == SW'(LOSS_CNT - 1)) begin
                     state_d = HUNT;
                     fill_d  = '0;
                     match_d = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + SW'(1);
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: state_d = HUNT;
         endcase
      end
      if (bus.clr) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HUNT;
         s_q     <= '0;
         fill_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.locked    = (state_q == LOCK);
   assign bus.err       = err_q;
   assign bus.err_count = cnt_q;
   assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_prbs4_checker.sv
// Randomised scoreboard bench for prbs4_checker with a sequence-level reference model.
module tb_prbs4_checker;
   localparam int LOCK_CNT = 8;
   localparam int LOSS_CNT = 3;
   localparam int CNT_W    = 2;
   localparam int W        = CNT_W + 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   prbs4_checker_if #(.CNT_W(CNT_W)) bus ();

   prbs4_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   // Reference: one period of the generator seeded 0001, plus history queues.
   bit period [15] = '{0,0,1,1,0,1,0,1,1,1,1,0,0,0,1};
   int idx = 0;
   bit hist[$];
   int m_match, m_miss;
   logic m_locked, m_err;
   logic [CNT_W-1:0] m_cnt;

   function automatic bit next_bit();
      bit b;
      b   = period[idx];
      idx = (idx + 1) % 15;
      return b;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_match = 0; m_miss = 0;
      m_locked = 1'b0; m_err = 1'b0; m_cnt = '0;
   endtask

   task automatic model_step(input logic v, input logic d, input logic c);
      bit pr;
      m_err = 1'b0;
      if (v) begin
         if (!m_locked) begin
            if (hist.size() == 4) begin
               pr = hist[0] ^ hist[1];
               if ((d == pr) && (hist[0] | hist[1] | hist[2] | hist[3])) m_match++;
               else m_match = 0;
            end
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            if (m_match == LOCK_CNT) begin
               m_locked = 1'b1; m_match = 0; m_miss = 0;
            end
         end else begin
            pr = hist[0] ^ hist[1];
            hist.push_back(pr);
            void'(hist.pop_front());
            if (d != pr) begin
               m_err = 1'b1;
               if (int'(m_cnt) < (1 << CNT_W) - 1) m_cnt = m_cnt + 1'b1;
               m_miss++;
               if (m_miss == LOSS_CNT) begin
                  m_locked = 1'b0; m_match = 0; m_miss = 0;
                  hist.delete();
               end
            end else begin
               m_miss = 0;
            end
         end
      end
      if (c) m_cnt = '0;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Driver
   task automatic cycle(input logic v, input logic d, input logic c);
      @(negedge clk); #1;
      bus.in_valid = v; bus.din = d; bus.clr = c;
      @(posedge clk);
      model_step(v, d, c);
      exp_q.push_back({m_locked, m_err, m_cnt});
   endtask

   task automatic send(input bit flip);
      cycle(1'b1, next_bit() ^ flip, 1'b0);
   endtask

   // Feeds correct bits until locked; returns valid bit count (bounded).
   task automatic count_to_lock(input bit gaps, output int n);
      n = 0;
      do begin
         send(1'b0);
         n++;
         #1;
         if (!bus.locked && gaps) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end while (!bus.locked && n < 40);
   endtask

   // Monitor
   initial begin
      logic [W-1:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.locked, bus.err, bus.err_count};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL scoreboard @%0t: got locked=%b err=%b cnt=%0d expected locked=%b err=%b cnt=%0d",
                        $time, a[W-1], a[W-2], a[CNT_W-1:0], e[W-1], e[W-2], e[CNT_W-1:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.in_valid = 1'b0; bus.din = 1'b0; bus.clr = 1'b0;
      model_reset();
      #12;
      check("reset_locked", int'(bus.locked), 0);
      check("reset_err", int'(bus.err), 0);
      check("reset_cnt", int'(bus.err_count), 0);
      rst = 1'b1;
      repeat (3) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);

      // Lock acquisition from seed 0001
      idx = 0;
      count_to_lock(1'b0, n);
      check("lock_bits", n, 12);
      repeat (6) send(1'b0);

      // Single error
      send(1'b1);
      repeat (8) send(1'b0);
      check("single_cnt", int'(bus.err_count), 1);

      // Loss of lock and relock
      cycle(1'b0, 1'b0, 1'b1);
      repeat (3) send(1'b1);
      #1;
      check("loss_locked", int'(bus.locked), 0);
      check("loss_cnt", int'(bus.err_count), 3);
      count_to_lock(1'b0, n);
      check("relock_bits", n, 12);
      check("relock_cnt", int'(bus.err_count), 3);

      // Two isolated errors then async reset mid-cycle
      cycle(1'b1, next_bit(), 1'b1);
      send(1'b1); send(1'b0); send(1'b1); send(1'b0);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check("arst_locked", int'(bus.locked), 0);
      check("arst_err", int'(bus.err), 0);
      check("arst_cnt", int'(bus.err_count), 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;

      // All-zero stream never locks
      repeat (40) cycle(1'b1, 1'b0, 1'b0);
      #1;
      check("zero_locked", int'(bus.locked), 0);

      // Gapped stream from a random phase
      idx = $urandom_range(0, 14);
      count_to_lock(1'b1, n);
      check("gap_lock_bits", n, 12);

      // Saturation and clear-wins
      for (int i = 0; i < 5; i++) begin
         send(1'b1);
         repeat ($urandom_range(1, 3)) send(1'b0);
      end
      check("sat_cnt", int'(bus.err_count), 3);
      cycle(1'b1, ~next_bit(), 1'b1);
      #1;
      check("clr_wins_cnt", int'(bus.err_count), 0);
      check("clr_err_pulse", int'(bus.err), 1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0),
               next_bit() ^ 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 31) == 0));
      end

      @(negedge clk); #2;
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
